// File: rtl/branch_cond_controller_pkg.sv
// Shared Bicc definitions: cond field encodings, PSR flag bit positions and
// the branch controller state encoding.
package branch_cond_controller_pkg;

  localparam logic [3:0] BICC_BN   = 4'b0000;
  localparam logic [3:0] BICC_BE   = 4'b0001;
  localparam logic [3:0] BICC_BLE  = 4'b0010;
  localparam logic [3:0] BICC_BL   = 4'b0011;
  localparam logic [3:0] BICC_BLEU = 4'b0100;
  localparam logic [3:0] BICC_BCS  = 4'b0101;
  localparam logic [3:0] BICC_BNEG = 4'b0110;
  localparam logic [3:0] BICC_BVS  = 4'b0111;
  localparam logic [3:0] BICC_BA   = 4'b1000;
  localparam logic [3:0] BICC_BNE  = 4'b1001;
  localparam logic [3:0] BICC_BG   = 4'b1010;
  localparam logic [3:0] BICC_BGE  = 4'b1011;
  localparam logic [3:0] BICC_BGU  = 4'b1100;
  localparam logic [3:0] BICC_BCC  = 4'b1101;
  localparam logic [3:0] BICC_BPOS = 4'b1110;
  localparam logic [3:0] BICC_BVC  = 4'b1111;

  // Flag vectors are packed {Z,N,C,V}
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_CC = 2'd1,
    DELAY   = 2'd2
  } state_e;

endpackage

// File: rtl/branch_cond_controller_if.sv
// Bundle between the ID stage / PSR side and the branch controller.
// The master drives the decoded branch and flags; the slave returns branch control.
interface branch_cond_controller_if #(parameter int CNT_W = 16);

  logic             br_valid;
  logic [3:0]       br_cond;
  logic             br_annul;
  logic [3:0]       psr_flags;
  logic             cc_pending;
  logic [3:0]       alu_flags;
  logic             stall;
  logic             stall_req;
  logic             take_branch;
  logic             annul_slot;
  logic             dcti_err;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output br_valid, br_cond, br_annul, psr_flags, cc_pending, alu_flags, stall,
    input  stall_req, take_branch, annul_slot, dcti_err, taken_cnt
  );

  modport slave (
    input  br_valid, br_cond, br_annul, psr_flags, cc_pending, alu_flags, stall,
    output stall_req, take_branch, annul_slot, dcti_err, taken_cnt
  );

endinterface

// File: rtl/branch_cond_controller_bicc_cond_eval.sv
// Combinational Bicc condition evaluator: cond field plus {Z,N,C,V} to taken/not-taken.
// cond[3] inverts the base condition selected by cond[2:0].
module bicc_cond_eval
  import branch_cond_controller_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       true_o
);

  logic z, n, c, v;
  logic baseCond;

  assign z = flags_i[FLAG_Z];
  assign n = flags_i[FLAG_N];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    baseCond = 1'b0;
    case (cond_i[2:0])
      3'b000:  baseCond = 1'b0;
      3'b001:  baseCond = z;
      3'b010:  baseCond = z | (n ^ v);
      3'b011:  baseCond = n ^ v;
      3'b100:  baseCond = c | z;
      3'b101:  baseCond = c;
      3'b110:  baseCond = n;
      default: baseCond = v;
    endcase
  end

  assign true_o = baseCond ^ cond_i[3];

endmodule

// File: rtl/branch_cond_controller.sv
// Bicc branch resolution controller: waits out PSR hazards, drives taken/annul for
// the delay slot and counts taken branches. Define CC_FORWARD_EN to bypass ALU flags.
module branch_cond_controller
  import branch_cond_controller_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic Clk,
  input  logic Clr,
  branch_cond_controller_if.slave bus
);

  state_e           state_q, state_d;
  logic [3:0]       cond_q, cond_d;
  logic             abit_q, abit_d;
  logic             stall_req_q, stall_req_d;
  logic             take_q, take_d;
  logic             annul_q, annul_d;
  logic             dcti_q, dcti_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] evalCond;
  logic [3:0] evalFlags;
  logic       evalAnnul;
  logic       condTrue;
  logic       annulNext;
  logic       enterDelay;

  // WAIT_CC resolves the branch latched while the PSR write was in flight
  assign evalCond  = (state_q == WAIT_CC) ? cond_q : bus.br_cond;
  assign evalAnnul = (state_q == WAIT_CC) ? abit_q : bus.br_annul;

`ifdef CC_FORWARD_EN
  assign evalFlags = (state_q == IDLE && bus.cc_pending) ? bus.alu_flags : bus.psr_flags;
`else
  logic unusedAluFlags;
  assign unusedAluFlags = ^bus.alu_flags;
  assign evalFlags      = bus.psr_flags;
`endif

  bicc_cond_eval u_eval (
    .cond_i  (evalCond),
    .flags_i (evalFlags),
    .true_o  (condTrue)
  );

  // BA keeps the delay slot unless annulled; every other kind annuls only when not taken
  assign annulNext = evalAnnul & ((evalCond == BICC_BA) | ~condTrue);

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q     <= IDLE;
      cond_q      <= 4'b0000;
      abit_q      <= 1'b0;
      stall_req_q <= 1'b0;
      take_q      <= 1'b0;
      annul_q     <= 1'b0;
      dcti_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cond_q      <= cond_d;
      abit_q      <= abit_d;
      stall_req_q <= stall_req_d;
      take_q      <= take_d;
      annul_q     <= annul_d;
      dcti_q      <= dcti_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cond_d      = cond_q;
    abit_d      = abit_q;
    stall_req_d = stall_req_q;
    take_d      = take_q;
    annul_d     = annul_q;
    dcti_d      = 1'b0;
    cnt_d       = cnt_q;
    enterDelay  = 1'b0;

    if (!bus.stall) begin
      case (state_q)
        IDLE: begin
          if (bus.br_valid) begin
`ifndef CC_FORWARD_EN
            if (bus.cc_pending) begin
              state_d     = WAIT_CC;
              stall_req_d = 1'b1;
              cond_d      = bus.br_cond;
              abit_d      = bus.br_annul;
            end else begin
              enterDelay = 1'b1;
            end
`else
            enterDelay = 1'b1;
`endif
          end
        end
        WAIT_CC: enterDelay = 1'b1;
        DELAY: begin
          state_d = IDLE;
          take_d  = 1'b0;
          annul_d = 1'b0;
          dcti_d  = bus.br_valid;
        end
        default: state_d = IDLE;
      endcase

      if (enterDelay) begin
        state_d     = DELAY;
        stall_req_d = 1'b0;
        take_d      = condTrue;
        annul_d     = annulNext;
        if (condTrue && cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.stall_req   = stall_req_q;
  assign bus.take_branch = take_q;
  assign bus.annul_slot  = annul_q;
  assign bus.dcti_err    = dcti_q;
  assign bus.taken_cnt   = cnt_q;

endmodule

// File: tb/tb_branch_cond_controller.sv
// Scoreboard bench for branch_cond_controller: stimulus pushes per-cycle expected
// outputs, a negedge monitor pops and compares. Runs a 16-bit and a 2-bit counter DUT.
`timescale 1ns/1ps
module tb_branch_cond_controller;
  import branch_cond_controller_pkg::*;

  logic       Clk;
  logic       Clr;
  logic       brValid;
  logic [3:0] brCond;
  logic       brAnnul;
  logic [3:0] psrFlags;
  logic       ccPending;
  logic [3:0] aluFlags;
  logic       stall;

  branch_cond_controller_if #(.CNT_W(16)) bus ();
  branch_cond_controller_if #(.CNT_W(2))  busNarrow ();

  assign bus.br_valid         = brValid;
  assign bus.br_cond          = brCond;
  assign bus.br_annul         = brAnnul;
  assign bus.psr_flags        = psrFlags;
  assign bus.cc_pending       = ccPending;
  assign bus.alu_flags        = aluFlags;
  assign bus.stall            = stall;
  assign busNarrow.br_valid   = brValid;
  assign busNarrow.br_cond    = brCond;
  assign busNarrow.br_annul   = brAnnul;
  assign busNarrow.psr_flags  = psrFlags;
  assign busNarrow.cc_pending = ccPending;
  assign busNarrow.alu_flags  = aluFlags;
  assign busNarrow.stall      = stall;

  branch_cond_controller #(.CNT_W(16)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  branch_cond_controller #(.CNT_W(2)) dutNarrow (
    .Clk (Clk),
    .Clr (Clr),
    .bus (busNarrow)
  );

  typedef struct {
    int   step;
    logic stallReq;
    logic take;
    logic annul;
    logic dcti;
    int   cnt;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   expCnt = 0;
  int   step   = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Spec truth table, written per cond value
  function automatic logic refCond(input logic [3:0] c, input logic [3:0] f);
    logic z, n, cf, v, r;
    z = f[3]; n = f[2]; cf = f[1]; v = f[0];
    r = 1'b0;
    case (c)
      4'b1000: r = 1'b1;
      4'b0000: r = 1'b0;
      4'b1001: r = !z;
      4'b0001: r = z;
      4'b1010: r = !(z | (n ^ v));
      4'b0010: r = z | (n ^ v);
      4'b1011: r = !(n ^ v);
      4'b0011: r = n ^ v;
      4'b1100: r = !(cf | z);
      4'b0100: r = cf | z;
      4'b1101: r = !cf;
      4'b0101: r = cf;
      4'b1110: r = !n;
      4'b0110: r = n;
      4'b1111: r = !v;
      default: r = v;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string what, input int stp,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %0d expected %0d", what, stp, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge
  task automatic applyStimulus(input logic clr, input logic v, input logic stl,
                               input logic ccp, input logic a, input logic [3:0] c,
                               input logic [3:0] f, input logic [3:0] alu,
                               input logic eStall, input logic eTake,
                               input logic eAnnul, input logic eDcti, input logic cntInc);
    exp_t e;
    @(negedge Clk);
    #1;
    Clr       = clr;
    brValid   = v;
    stall     = stl;
    ccPending = ccp;
    brAnnul   = a;
    brCond    = c;
    psrFlags  = f;
    aluFlags  = alu;
    if (clr) expCnt = 0;
    else if (cntInc) expCnt++;
    step++;
    e.step     = step;
    e.stallReq = eStall;
    e.take     = eTake;
    e.annul    = eAnnul;
    e.dcti     = eDcti;
    e.cnt      = expCnt;
    expQ.push_back(e);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Unhazarded branch followed by the delay-slot cycle
  task automatic branchPair(input logic [3:0] c, input logic a, input logic [3:0] f,
                            input logic eTake, input logic eAnnul);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, a, c, f, 4'b0000,
                  1'b0, eTake, eAnnul, 1'b0, eTake);
    idleCycle();
  endtask

  initial begin : monitor
    exp_t e;
    int   narrowExp;
    forever begin
      @(negedge Clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        narrowExp = (e.cnt > 3) ? 3 : e.cnt;
        checkOutput("stall_req",   e.step, 32'(bus.stall_req),   32'(e.stallReq));
        checkOutput("take_branch", e.step, 32'(bus.take_branch), 32'(e.take));
        checkOutput("annul_slot",  e.step, 32'(bus.annul_slot),  32'(e.annul));
        checkOutput("dcti_err",    e.step, 32'(bus.dcti_err),    32'(e.dcti));
        checkOutput("taken_cnt",   e.step, 32'(bus.taken_cnt),   32'(e.cnt));
        checkOutput("taken_cnt_w2", e.step, 32'(busNarrow.taken_cnt), 32'(narrowExp));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] cv, fv;
    logic       av, tv, anv;
    Clr = 1'b1; brValid = 1'b0; stall = 1'b0; ccPending = 1'b0;
    brAnnul = 1'b0; brCond = 4'b0000; psrFlags = 4'b0000; aluFlags = 4'b0000;

    // Reset state, then release
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle();

    // Hazarded BE, then Clr while the controller sits in WAIT_CC (or DELAY when forwarding)
`ifdef CC_FORWARD_EN
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, BICC_BE, 4'b0000, 4'b1000,
                  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
`else
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, BICC_BE, 4'b0000, 4'b1000,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle();

    // Five taken branches from a cleared counter: 16-bit reads 5, 2-bit saturates at 3
    repeat (5) branchPair(BICC_BA, 1'b0, 4'b0000, 1'b1, 1'b0);

    // Annul behaviour
    branchPair(BICC_BA,  1'b1, 4'b0000, 1'b1, 1'b1);
    branchPair(BICC_BE,  1'b1, 4'b0000, 1'b0, 1'b1);
    branchPair(BICC_BE,  1'b1, 4'b1000, 1'b1, 1'b0);
    branchPair(BICC_BN,  1'b1, 4'b1111, 1'b0, 1'b1);
    branchPair(BICC_BNE, 1'b0, 4'b0000, 1'b1, 1'b0);

    // Condition-code hazard
`ifdef CC_FORWARD_EN
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, BICC_BE, 4'b0000, 4'b1000,
                  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idleCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, BICC_BE, 4'b1000, 4'b0000,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idleCycle();
    // Stall right after a forwarded branch holds DELAY
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, BICC_BA, 4'b0000, 4'b0000,
                  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, BICC_BA, 4'b0000, 4'b0000,
                  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, BICC_BE, 4'b0000, 4'b0000,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, BICC_BE, 4'b1000, 4'b0000,
                  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idleCycle();
    // Stale PSR says taken, updated PSR says not taken
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, BICC_BE, 4'b1000, 4'b0000,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, BICC_BE, 4'b0000, 4'b0000,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idleCycle();
    // Stall while waiting holds WAIT_CC and stall_req
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, BICC_BA, 4'b0000, 4'b0000,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, BICC_BA, 4'b0000, 4'b0000,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, BICC_BA, 4'b0000, 4'b0000,
                  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
`endif
    idleCycle();

    // Three stalled cycles in DELAY hold the outputs; DELAY exits once stall drops
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, BICC_BA, 4'b0000, 4'b0000,
                  1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000,
                             1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idleCycle();
    idleCycle();

    // Branch in the delay slot flags dcti_err, but not while stalled
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, BICC_BNE, 4'b0000, 4'b0000,
                  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, BICC_BA, 4'b0000, 4'b0000,
                  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, BICC_BA, 4'b0000, 4'b0000,
                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idleCycle();

    // A stalled IDLE ignores br_valid
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, BICC_BA, 4'b0000, 4'b0000,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle();

    // Full condition table sweep
    for (int ci = 0; ci < 16; ci++) begin
      for (int fi = 0; fi < 16; fi++) begin
        cv = 4'(ci);
        fv = 4'(fi);
        av = cv[0] ^ fv[0] ^ fv[3];
        tv = refCond(cv, fv);
        if (cv == 4'b1000) anv = av;
        else if (tv)       anv = 1'b0;
        else               anv = av;
        branchPair(cv, av, fv, tv, anv);
      end
    end

    repeat (3) @(negedge Clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_cond_controller.md
Name: branch_cond_controller

Overview:
- Sequences SPARC Bicc branch resolution against the Program Status Register condition flags.
- Sits between the ID stage and the PC/NPC logic.
- Latches the decoded branch, waits out condition-code hazards, and evaluates the 16 Bicc conditions.
- Drives the branch-taken select and delay-slot annul control; counts taken branches for debug.

Parameters:
- CNT_W, 16: width of the saturating taken-branch counter.

Ports:
- Clk  in  1  clock; rising edge.
- Clr  in  1  asynchronous active-high reset.
- br_valid  in  1  ID stage holds a Bicc this cycle.
- br_cond  in  4  Bicc cond field, bits 28:25.
- br_annul  in  1  Bicc 'a' bit.
- psr_flags  in  4  PSR flag register output, {Z,N,C,V}.
- cc_pending  in  1  older in-flight instruction writes the PSR at this cycle's edge.
- alu_flags  in  4  {Z,N,C,V} being written to the PSR this cycle (used only with CC_FORWARD_EN).
- stall  in  1  pipeline freeze; the FSM holds state.
- stall_req  out  1  controller requests a pipeline freeze.
- take_branch  out  1  NPC selects the branch target.
- annul_slot  out  1  squash the delay-slot instruction.
- dcti_err  out  1  one-cycle pulse: branch in delay slot, which is unsupported.
- taken_cnt  out  CNT_W  saturating count of taken branches.

Behaviour:
- Reset: all outputs 0, state IDLE, latched branch fields cleared.
- Clr takes effect immediately at any point, including mid-WAIT_CC or mid-DELAY.
- Condition truth table (f = {Z,N,C,V}):
  - 1000 true; 0000 false.
  - 1001 !Z; 0001 Z.
  - 1010 !(Z|(N^V)); 0010 Z|(N^V).
  - 1011 !(N^V); 0011 N^V.
  - 1100 !(C|Z); 0100 C|Z.
  - 1101 !C; 0101 C.
  - 1110 !N; 0110 N.
  - 1111 !V; 0111 V.
- Three states: IDLE, WAIT_CC, DELAY. All outputs are registered.
- Every state holds while stall=1. Outputs hold too, except dcti_err, which drops.
- IDLE:
  - br_valid=1 and cc_pending=0: evaluate on psr_flags, go to DELAY next cycle.
  - br_valid=1 and cc_pending=1: latch cond/annul, go to WAIT_CC; stall_req=1 during WAIT_CC.
  - br_valid=0: stay IDLE.
- WAIT_CC: exactly one unstalled cycle. Evaluate the latched branch on psr_flags (now updated), then go to DELAY; stall_req=0 in DELAY.
- DELAY: take_branch and annul_slot are valid for this state only; both are 0 in other states. Values by branch kind:
  - cond=1000 (BA): take=1, annul=br_annul.
  - cond=0000 (BN): take=0, annul=br_annul.
  - Other conditions, true: take=1, annul=0.
  - Other conditions, false: take=0, annul=br_annul.
- DELAY lasts one unstalled cycle, then returns to IDLE.
- br_valid=1 while in DELAY: the branch is ignored, dcti_err pulses on the next cycle.
- Latency: br_valid in cycle t gives take_branch in cycle t+1 without a hazard, t+2 with a hazard (no stalls).
- taken_cnt increments on entry to DELAY with take=1 and saturates at all-ones; no wrap.

Optional Feature:
- Macro: CC_FORWARD_EN.
- Defined: when cc_pending=1 in IDLE, evaluate on alu_flags and go directly to DELAY. WAIT_CC is never entered and stall_req stays 0.
- Undefined: the WAIT_CC stall path as described above; alu_flags is unused.

Decomposition:
- Shared package: Bicc cond encodings (BA=4'b1000 ... BVS=4'b0111), flag bit indices (Z=3, N=2, C=1, V=0), and the state encoding (IDLE=2'd0, WAIT_CC=2'd1, DELAY=2'd2).
- One sub-module: bicc_cond_eval, a combinational function of (cond, flags) to the true/false result, reused by the branch unit and other users of the flags.

Test Plan:
- Reset: Clr=1 then 0 -> all outputs 0 and taken_cnt=0. Assert Clr in WAIT_CC -> next cycle IDLE with stall_req=0.
- Table sweep: all 16 cond values × all 16 psr_flags values, cc_pending=0 -> take_branch matches the truth table one cycle later. Example: cond=1001 with flags 4'b0000 -> take=1.
- Annul: BA with a=1 -> take=1, annul=1. BE with a=1 and Z=0 -> take=0, annul=1. BE with a=1 and Z=1 -> take=1, annul=0.
- Hazard, CC_FORWARD_EN undefined: cc_pending=1, cond=0001, psr_flags 0000→1000 at the edge -> stall_req=1 for one cycle, then take=1 at t+2.
- Hazard, CC_FORWARD_EN defined: cc_pending=1, alu_flags=1000 -> take=1 at t+1, stall_req stays 0.
- Edge cases:
  - stall=1 for 3 cycles during DELAY -> outputs held, DELAY exits after stall drops.
  - br_valid in DELAY -> dcti_err pulses.
  - CNT_W=2 with 5 taken branches -> taken_cnt=3.
